ir_line_detect: RTL
===================

// Module: ir_line_detect
// PURPOSE
//  Parametrised IR line-sensor front end; consumes per-channel ADC samples (NUM_CH x ADC_W)
//  each time the ADC controller delivers a sample set. Per-channel hysteresis thresholding
//  plus N-sample debounce, per-channel output polarity. Emits a clean detect vector with
//  valid/change pulses for the line-follow controller and status LEDs.
// PARAMETERS
//  NUM_CH    3         number of IR channels
//  ADC_W     12        sample width, unsigned
//  TH_HIGH   12'h800   rise threshold; sample > TH_HIGH arms a 0->1 transition
//  TH_LOW    12'h700   fall threshold; sample < TH_LOW arms a 1->0 transition (TH_LOW <= TH_HIGH)
//  DEBOUNCE  4         consecutive qualifying samples needed to switch state (>= 1)
//  POLARITY  3'b110    per-channel output inversion; det[i] = state[i] ^ POLARITY[i]
// PORTS
//  clk_50        in   1             system clock, 50 MHz
//  rst           in   1             synchronous, active-high reset
//  sample_valid  in   1             one-cycle strobe: sample_data holds a new sample set
//  sample_data   in   NUM_CH*ADC_W  channel i at [i*ADC_W +: ADC_W]
//  det           out  NUM_CH        debounced, polarity-applied detect vector
//  det_valid     out  1             one-cycle pulse: det updated for an accepted sample set
//  det_change    out  1             one-cycle pulse with det_valid when any det bit toggled
// BEHAVIOUR
//  - All registers in clk_50 domain. rst wins over sample_valid on the same edge.
//  - Reset: state=0, cnt=0 (all ch); det=POLARITY; det_valid=0; det_change=0.
//  - Per channel i, evaluated only on edges with sample_valid=1:
//      cand = state ? !(s < TH_LOW) : (s > TH_HIGH)   (strict compares; TH values never qualify)
//      cand == state          -> cnt <= 0
//      cand != state, cnt < DEBOUNCE-1 -> cnt <= cnt+1
//      cand != state, cnt == DEBOUNCE-1 -> state <= cand, cnt <= 0
//  - DEBOUNCE=1: state switches on first qualifying sample. cnt width = clog2(DEBOUNCE) min 1;
//    cnt never exceeds DEBOUNCE-1, no wrap.
//  - Samples in [TH_LOW, TH_HIGH] hold state and clear cnt unless they qualify for the
//    pending direction (i.e. band samples break a debounce run in either direction).
//  - Cycles with sample_valid=0: state, cnt, det held; det_valid=det_change=0.
//  - det, det_valid, det_change registered, updated on the sample_valid edge: latency 1 clk
//    from the Nth qualifying sample to det change. det_valid = registered sample_valid.
//    det_change = |(det_next ^ det) on that edge.
//  - Channels fully independent; simultaneous switches on several channels give a single
//    det_change pulse.
//  - Back-to-back sample_valid (every cycle) supported; one det_valid per strobe.
//  - rst mid-debounce discards partial counts; next transition needs DEBOUNCE fresh samples.
// TESTING (defaults unless noted)
//  1 rst high 2 clk -> det=3'b110, det_valid=0, det_change=0; hold sample_valid=1 during rst -> no pulse.
//  2 ch0=12'h900 x4 strobes (others 0) -> after strobe 3 det=3'b110, change=0; 1 clk after
//    strobe 4 det=3'b111, det_valid=1, det_change=1.
//  3 ch0: 900,900,900,000,900,900,900 -> det[0] never changes; det_change=0 throughout.
//  4 ch0 set high, then 12'h750 x10 -> det[0] stays 1; then 12'h6FF x4 -> det[0]=0 after 4th;
//    12'h800 x8 from state 0 -> no rise (strict compare).
//  5 strobes separated by 0..7 idle clocks, ch1=12'hFFF x4 -> det[1] 1->0 after 4th strobe;
//    det_valid count equals strobe count exactly.
//  6 ch2=12'hA00 x3, rst 1 clk, ch2=12'hA00 x3 -> no change; 4th post-reset strobe -> det[2]=0.
//    Also NUM_CH=8, DEBOUNCE=1 build: single sample toggles det bit immediately.

Source files
------------

// File: rtl/ir_line_detect_if.sv
// ---------------------------------------------------------------------------
// ir_line_detect_if
// Sample-in / detect-out bundle between the ADC controller, the IR line
// detector and its consumers (line-follow controller, status LEDs).
//   sample_valid  one-cycle strobe, sample_data holds a new sample set
//   sample_data   NUM_CH x ADC_W packed samples, channel i at [i*ADC_W +: ADC_W]
//   det           debounced, polarity-applied detect vector
//   det_valid     one-cycle pulse, det updated for an accepted sample set
//   det_change    one-cycle pulse with det_valid when any det bit toggled
// master : sample producer / detect consumer side
// slave  : the detector itself
// ---------------------------------------------------------------------------
interface ir_line_detect_if #(
    parameter int NUM_CH = 3,
    parameter int ADC_W  = 12
);
    logic                       sample_valid;
    logic [NUM_CH*ADC_W-1:0]    sample_data;
    logic [NUM_CH-1:0]          det;
    logic                       det_valid;
    logic                       det_change;

    modport master (
        output sample_valid,
        output sample_data,
        input  det,
        input  det_valid,
        input  det_change
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output det,
        output det_valid,
        output det_change
    );
endinterface

// File: rtl/ir_line_detect.sv
// ---------------------------------------------------------------------------
// ir_line_detect
// IR line-sensor front end. For every accepted ADC sample set, each channel
// runs a hysteresis comparator (rise above TH_HIGH, fall below TH_LOW) whose
// result must persist for DEBOUNCE consecutive sample sets before the channel
// state flips. The detect vector is state XOR POLARITY, registered, with a
// det_valid pulse per accepted set and a det_change pulse when any bit moved.
// Ports:
//   clk_50  system clock (all state in this domain)
//   rst     synchronous active-high reset, dominates sample_valid
//   bus     ir_line_detect_if slave modport (sample in, detect out)
// ---------------------------------------------------------------------------
module ir_line_detect #(
    parameter int                NUM_CH   = 3,
    parameter int                ADC_W    = 12,
    parameter logic [ADC_W-1:0]  TH_HIGH  = 12'h800,
    parameter logic [ADC_W-1:0]  TH_LOW   = 12'h700,
    parameter int                DEBOUNCE = 4,
    parameter logic [NUM_CH-1:0] POLARITY = 3'b110
) (
    input  logic            clk_50,
    input  logic            rst,
    ir_line_detect_if.slave bus
);

    // A single-sample debounce still needs a 1-bit counter to keep the
    // datapath uniform; it simply never leaves zero.
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);

    // Hysteresis candidate: while high, anything not strictly below TH_LOW
    // keeps the channel high; while low, only samples strictly above TH_HIGH
    // propose a rise. Threshold values themselves never qualify a switch.
    function automatic logic hyst_cand(input logic cur, input logic [ADC_W-1:0] s);
        logic res;
        if (cur) begin
            res = !(s < TH_LOW);
        end else begin
            res = (s > TH_HIGH);
        end
        return res;
    endfunction

    logic [NUM_CH-1:0] state_r;
    logic [CNT_W-1:0]  cnt_r      [NUM_CH];
    logic [NUM_CH-1:0] det_r;
    logic              det_valid_r;
    logic              det_change_r;

    logic [NUM_CH-1:0] state_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s  [NUM_CH];
    logic [NUM_CH-1:0] cand_s;
    logic [NUM_CH-1:0] det_nxt_s;
    logic              change_s;

    // Per-channel debounce step assuming the current cycle carries a sample set.
    always_comb begin
        state_nxt_s = state_r;
        cand_s      = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            cand_s[i]    = hyst_cand(state_r[i], bus.sample_data[i*ADC_W +: ADC_W]);
            if (cand_s[i] == state_r[i]) begin
                // Agreeing (or in-band) sample breaks any pending run.
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] < CNT_MAX) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else begin
                state_nxt_s[i] = cand_s[i];
                cnt_nxt_s[i]   = CNT_ZERO;
            end
        end
        det_nxt_s = state_nxt_s ^ POLARITY;
        change_s  = |(det_nxt_s ^ det_r);
    end

    // State, counters and registered outputs; advance only on accepted sample sets.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_r      <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            det_r        <= POLARITY;
            det_valid_r  <= 1'b0;
            det_change_r <= 1'b0;
        end else if (bus.sample_valid) begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            det_r        <= det_nxt_s;
            det_valid_r  <= 1'b1;
            det_change_r <= change_s;
        end else begin
            det_valid_r  <= 1'b0;
            det_change_r <= 1'b0;
        end
    end

    assign bus.det        = det_r;
    assign bus.det_valid  = det_valid_r;
    assign bus.det_change = det_change_r;

endmodule
